// File: rtl/vga_scanout.sv
// VGA 640x480@60 scanout: timing generator, framebuffer read port driver and RGB332 pin unpacking.
// Each 8-bit framebuffer byte fills a (1<<SCALE_SHIFT)-square pixel block.
module vga_scanout #(
  parameter int CLK_DIV     = 2,
  parameter int SCALE_SHIFT = 2,
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] fb_addr,
  input  logic [DATA_WIDTH-1:0] fb_data,
  output logic [2:0]            vga_r,
  output logic [2:0]            vga_g,
  output logic [1:0]            vga_b,
  output logic                  vga_hsync,
  output logic                  vga_vsync,
  output logic                  vga_blank_n,
  output logic                  vblank,
  output logic                  frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0]         DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0]         H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]         H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0]         HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]         HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0]         V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]         V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0]         VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]         VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [ADDR_WIDTH-1:0] FB_W     = ADDR_WIDTH'(H_ACTIVE >> SCALE_SHIFT);

  // Blanked pixels are forced black whatever the memory returns.
  function automatic logic [7:0] rgb332_gate(input logic en, input logic [DATA_WIDTH-1:0] d);
    rgb332_gate = en ? d[7:0] : 8'd0;
  endfunction

  logic [DW-1:0]         div_cnt;
  logic                  tick;
  logic [HW-1:0]         h;
  logic [VW-1:0]         v;
  logic [VW-1:0]         v_next;
  logic                  row_edge;
  logic [ADDR_WIDTH-1:0] row_base;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  active;
  logic                  hs_n;
  logic                  vs_n;
  logic                  active_p1;
  logic                  hs_p1;
  logic                  vs_p1;
  logic [7:0]            rgb_p2;

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  // row_base tracks (v >> SCALE_SHIFT) * FB_W incrementally, so no multiplier is needed.
  always_comb begin
    v_next   = (v == V_LAST) ? '0 : v + 1'b1;
    row_edge = (v_next < V_ACT) && (((v_next >> SCALE_SHIFT) << SCALE_SHIFT) == v_next);
  end

  // Stage 0: pixel/line counters, address base and undelayed vblank
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h        <= '0;
      v        <= '0;
      row_base <= '0;
      vblank   <= 1'b0;
    end else if (tick) begin
      if (h == H_LAST) begin
        h      <= '0;
        v      <= v_next;
        vblank <= (v_next >= V_ACT);
        if (v == V_LAST)  row_base <= '0;
        else if (row_edge) row_base <= row_base + FB_W;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_start <= 1'b0;
    else     frame_start <= tick && (h == H_LAST) && (v == V_LAST);
  end

  always_comb begin
    active = (h < H_ACT) && (v < V_ACT);
    hs_n   = !((h >= HS_BEG) && (h < HS_END));
    vs_n   = !((v >= VS_BEG) && (v < VS_END));
    addr   = row_base + ADDR_WIDTH'(h >> SCALE_SHIFT);
  end

  // Stage 1: issue the memory read; sync/active follow so they stay aligned with the data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_addr   <= '0;
      active_p1 <= 1'b0;
      hs_p1     <= 1'b1;
      vs_p1     <= 1'b1;
    end else if (tick) begin
      fb_addr   <= active ? addr : '0;
      active_p1 <= active;
      hs_p1     <= hs_n;
      vs_p1     <= vs_n;
    end
  end

  // Stage 2: memory data has arrived (CLK_DIV >= 2); drive the pins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_p2      <= 8'd0;
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      vga_blank_n <= 1'b0;
    end else if (tick) begin
      rgb_p2      <= rgb332_gate(active_p1, fb_data);
      vga_hsync   <= hs_p1;
      vga_vsync   <= vs_p1;
      vga_blank_n <= active_p1;
    end
  end

  assign vga_r = rgb_p2[7:5];
  assign vga_g = rgb_p2[4:2];
  assign vga_b = rgb_p2[1:0];

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: per-clock comparison against a position-based model of the raster,
// with a shortened vertical frame so whole frames fit in a short run.
module tb_vga_scanout;

  localparam int CD = 2;
  localparam int HA = 640, HF = 16, HS = 96, HB = 48;
  localparam int VA = 12,  VF = 1,  VS = 2,  VB = 2;
  localparam int HT  = HA + HF + HS + HB;
  localparam int VT  = VA + VF + VS + VB;
  localparam int TOT = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] fb_addr;
  logic [7:0]  fb_data;
  logic [2:0]  vga_r, vga_g;
  logic [1:0]  vga_b;
  logic        vga_hsync, vga_vsync, vga_blank_n, vblank, frame_start;

  vga_scanout #(
    .CLK_DIV(CD), .SCALE_SHIFT(2), .ADDR_WIDTH(16), .DATA_WIDTH(8),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst(rst), .fb_addr(fb_addr), .fb_data(fb_data),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_blank_n(vga_blank_n),
    .vblank(vblank), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Frame memory with a 1-clk registered read port
  logic [7:0] mem [0:65535];
  always @(posedge clk) fb_data <= mem[fb_addr];

  // Clock edges seen since reset was last released
  longint n = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  int total  = 0;
  int passed = 0;
  bit run_chk = 0;
  bit lit_on  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s n=%0d: got %0d, want %0d", name, n, act, exp);
  endtask

  function automatic bit vis(input longint q);
    return ((q % HT) < HA) && ((q / HT) < VA);
  endfunction

  function automatic int addr_of(input longint q);
    return int'(((q / HT) / 4) * (HA / 4) + (q % HT) / 4);
  endfunction

  function automatic bit in_win(input longint x, input int beg, input int len);
    return (x >= beg) && (x < beg + len);
  endfunction

  function automatic logic sig(input int sel);
    case (sel)
      0:       return vga_hsync;
      1:       return vga_vsync;
      2:       return vblank;
      default: return frame_start;
    endcase
  endfunction

  // Raster position k = ticks since reset; stage 1 shows position k-1, pins show k-2.
  always @(negedge clk) begin : cmp
    longint k, p, q1, q2;
    int ea;
    logic [7:0] erg, grg;
    logic ehs, evs, ebl;
    if (run_chk) begin
      k = n / CD;
      p = k % TOT;
      chk("vblank", longint'(vblank), longint'((p / HT) >= VA));
      chk("frame_start", longint'(frame_start), longint'((n % CD == 0) && (k > 0) && (p == 0)));
      q1 = (k >= 1) ? (k - 1) % TOT : -1;
      ea = 0;
      if (k >= 1 && vis(q1)) ea = addr_of(q1);
      chk("fb_addr", longint'(fb_addr), longint'(ea));
      q2 = -1; ehs = 1'b1; evs = 1'b1; ebl = 1'b0; erg = 8'd0;
      if (k >= 2) begin
        q2  = (k - 2) % TOT;
        ehs = !in_win(q2 % HT, HA + HF, HS);
        evs = !in_win(q2 / HT, VA + VF, VS);
        ebl = vis(q2);
        erg = ebl ? mem[addr_of(q2)] : 8'd0;
      end
      grg = {vga_r, vga_g, vga_b};
      chk("hsync",   longint'(vga_hsync),   longint'(ehs));
      chk("vsync",   longint'(vga_vsync),   longint'(evs));
      chk("blank_n", longint'(vga_blank_n), longint'(ebl));
      chk("rgb",     longint'(grg),         longint'(erg));
      if (lit_on && (n % CD == 0)) begin
        case (q1)
          4:       chk("lit_addr_4_0",   longint'(fb_addr), 1);
          639:     chk("lit_addr_639_0", longint'(fb_addr), 159);
          700:     chk("lit_addr_700_0", longint'(fb_addr), 0);
          3200:    chk("lit_addr_0_4",   longint'(fb_addr), 160);
          9439:    chk("lit_addr_639_11", longint'(fb_addr), 479);
          default: ;
        endcase
        case (q2)
          4:       chk("lit_rgb_4_0",   longint'(grg), 8'h01);
          28:      chk("lit_rgb_28_0",  longint'(grg), 8'h07);
          650:     chk("lit_rgb_650_0", longint'(grg), 0);
          3200:    chk("lit_rgb_0_4",   longint'(grg), 8'hA0);
          default: ;
        endcase
      end
    end
  end

  task automatic wait_for(input int sel, input logic val, input int bound, input string name);
    int i = 0;
    while (sig(sel) !== val && i < bound) begin
      @(negedge clk);
      i++;
    end
    if (sig(sel) !== val) begin
      total++;
      $display("FAIL %s timeout: got no %0d within %0d clk", name, val, bound);
    end
  endtask

  task automatic reset_check(input string pfx);
    chk({pfx, "_fb_addr"},     longint'(fb_addr), 0);
    chk({pfx, "_rgb"},         longint'({vga_r, vga_g, vga_b}), 0);
    chk({pfx, "_hsync"},       longint'(vga_hsync), 1);
    chk({pfx, "_vsync"},       longint'(vga_vsync), 1);
    chk({pfx, "_blank_n"},     longint'(vga_blank_n), 0);
    chk({pfx, "_vblank"},      longint'(vblank), 0);
    chk({pfx, "_frame_start"}, longint'(frame_start), 0);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = a[7:0];
    run_chk = 1;
    repeat (3) @(posedge clk);
    #1 reset_check("por");
    @(posedge clk); #2 rst = 1'b0;
    lit_on = 1;
    @(negedge clk);
    wait_for(0, 1'b0, 5000, "hs_fall");
    chk("first_hs_fall_clk", n, 1316);
    wait_for(0, 1'b1, 1000, "hs_rise");
    chk("hs_rise_clk", n, 1508);
    wait_for(2, 1'b1, 30000, "vblank_rise");
    chk("vblank_rise_clk", n, 19200);
    wait_for(1, 1'b0, 5000, "vs_fall");
    chk("vs_fall_clk", n, 20804);
    wait_for(1, 1'b1, 5000, "vs_rise");
    chk("vs_rise_clk", n, 24004);
    wait_for(3, 1'b1, 5000, "frame_start");
    chk("frame_start_clk", n, 27200);
    repeat (2000) @(negedge clk);
    lit_on = 0;

    // Random framebuffer contents, random mid-frame reset
    @(posedge clk); #2 rst = 1'b1;
    #1 reset_check("rst_a");
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    repeat (3) @(posedge clk); #2 rst = 1'b0;
    repeat ($urandom_range(20000, 32000)) @(posedge clk);
    #2 rst = 1'b1;
    #1 reset_check("rst_mid");
    repeat (2) @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    wait_for(0, 1'b0, 5000, "hs_fall2");
    chk("hs_fall_after_mid_rst_clk", n, 1316);
    repeat (3000) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
